// File: rtl/toaplan2_snd_pkg.sv
// Shared types for the Toaplan2 sound path: PCM arbiter state encoding, bus widths, channel index.
package toaplan2_snd_pkg;

    localparam int PCM_AW = 20;
    localparam int OKI_AW = 18;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_WAIT   = 2'd2
    } pcm_state_t;

    typedef logic chan_t;

endpackage

// File: rtl/toaplan2_pcm_slot.sv
// One-byte ROM cache for a single OKI channel: valid/tag/data plus address compare.
// Latency: OK follows the requester address combinationally; a load is visible the next cycle.
// Backpressure: none; the requester simply holds its address until OK rises.
module toaplan2_pcm_slot
    import toaplan2_snd_pkg::*;
(
    input  logic              CLK96,
    input  logic              RESET96,
    input  logic [OKI_AW-1:0] addr,
    input  logic              load,
    input  logic [OKI_AW-1:0] load_tag,
    input  logic [7:0]        load_data,
    output logic              ok,
    output logic [7:0]        dout
);

    logic              valid;
    logic [OKI_AW-1:0] tag;
    logic [7:0]        data;

    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            tag   <= load_tag;
            data  <= load_data;
        end
    end

    assign ok   = valid && (addr == tag);
    assign dout = data;

endmodule

// File: rtl/toaplan2_pcm_arbiter.sv
// Shares one PCM ROM port between two jt6295 channels, each with a one-byte cache, misses served round-robin.
// Latency: a miss gives OK SETTLE+2 cycles after the address change when PCM_OK is already high.
// Backpressure: the requester waits on OKIn_OK; the ROM stalls via PCM_OK, bounded by TIMEOUT.
module toaplan2_pcm_arbiter
    import toaplan2_snd_pkg::*;
#(
    parameter int DUAL    = 1,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK96,
    input  logic              RESET96,
    input  logic [OKI_AW-1:0] OKI0_ADDR,
    output logic [7:0]        OKI0_DOUT,
    output logic              OKI0_OK,
    input  logic [OKI_AW-1:0] OKI1_ADDR,
    output logic [7:0]        OKI1_DOUT,
    output logic              OKI1_OK,
    input  logic [PCM_AW-1:0] OKI1_BASE,
    output logic              PCM_CS,
    output logic [PCM_AW-1:0] PCM_ADDR,
    input  logic [7:0]        PCM_DOUT,
    input  logic              PCM_OK,
    output logic              TMO_ERR
);

    localparam bit         DUAL_EN     = (DUAL != 0);
    localparam logic [9:0] SETTLE_LAST = 10'(SETTLE - 1);
    localparam logic [9:0] TMO_LAST    = 10'(TIMEOUT - 1);

    pcm_state_t        state;
    chan_t             rr;
    chan_t             g;
    logic [OKI_AW-1:0] lat_addr;
    logic [9:0]        cnt;

    logic              ok0, ok1;
    logic [7:0]        dout0, dout1;
    logic              pend0, pend1;
    logic              gnt_vld;
    chan_t             gnt_ch;
    logic [OKI_AW-1:0] gnt_addr;
    logic [PCM_AW-1:0] gnt_base;
    logic              cap;
    logic              load0, load1;

    always_comb begin
        pend0    = !ok0;
        pend1    = DUAL_EN && !ok1;
        gnt_vld  = pend0 || pend1;
        gnt_ch   = (pend0 && pend1) ? rr : chan_t'(pend1);
        gnt_addr = gnt_ch ? OKI1_ADDR : OKI0_ADDR;
        gnt_base = gnt_ch ? OKI1_BASE : '0;
    end

    // Capture uses the latched address, so a requester that moved on still gets a valid (but mismatching) tag.
    assign cap   = (state == ST_WAIT) && PCM_OK;
    assign load0 = cap && (g == 1'b0);
    assign load1 = cap && (g == 1'b1) && DUAL_EN;

    toaplan2_pcm_slot u_slot0 (
        .CLK96     (CLK96),
        .RESET96   (RESET96),
        .addr      (OKI0_ADDR),
        .load      (load0),
        .load_tag  (lat_addr),
        .load_data (PCM_DOUT),
        .ok        (ok0),
        .dout      (dout0)
    );

    toaplan2_pcm_slot u_slot1 (
        .CLK96     (CLK96),
        .RESET96   (RESET96),
        .addr      (OKI1_ADDR),
        .load      (load1),
        .load_tag  (lat_addr),
        .load_data (PCM_DOUT),
        .ok        (ok1),
        .dout      (dout1)
    );

    assign OKI0_OK   = ok0;
    assign OKI0_DOUT = dout0;
    assign OKI1_OK   = DUAL_EN ? ok1 : 1'b0;
    assign OKI1_DOUT = DUAL_EN ? dout1 : 8'h00;

    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            state    <= ST_IDLE;
            rr       <= 1'b0;
            g        <= 1'b0;
            lat_addr <= '0;
            cnt      <= '0;
            PCM_CS   <= 1'b0;
            PCM_ADDR <= '0;
            TMO_ERR  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        lat_addr <= gnt_addr;
                        g        <= gnt_ch;
                        PCM_ADDR <= {{(PCM_AW-OKI_AW){1'b0}}, gnt_addr} + gnt_base;
                        PCM_CS   <= 1'b1;
                        cnt      <= '0;
                        state    <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        state <= ST_WAIT;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                ST_WAIT: begin
                    if (PCM_OK) begin
                        PCM_CS <= 1'b0;
                        rr     <= !g;
                        state  <= ST_IDLE;
                    end else if (cnt == TMO_LAST) begin
                        PCM_CS  <= 1'b0;
                        TMO_ERR <= 1'b1;
                        rr      <= !g;
                        state   <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_toaplan2_pcm_arbiter.sv
// Bench for the dual-OKI PCM arbiter: a DUAL=1 instance and a DUAL=0 instance, each with its own ROM model.
module tb_toaplan2_pcm_arbiter;

    localparam int T_SETTLE  = 2;
    localparam int T_TIMEOUT = 255;

    logic CLK96   = 1'b0;
    logic RESET96 = 1'b1;
    always #5 CLK96 = ~CLK96;

    int checks = 0;
    int errors = 0;

    logic [17:0] a0_addr = '0, a1_addr = '0;
    logic [19:0] a1_base = '0;
    logic [7:0]  a0_dout, a1_dout, a_pdout;
    logic        a0_ok, a1_ok, a_cs, a_pok, a_tmo;
    logic [19:0] a_paddr;
    logic        a_rom_en = 1'b1;
    int          a_dly = 1;
    int          a_cyc = 0;

    logic [17:0] s0_addr = '0, s1_addr = '0;
    logic [19:0] s1_base = 20'h40000;
    logic [7:0]  s0_dout, s1_dout, s_pdout;
    logic        s0_ok, s1_ok, s_cs, s_pok, s_tmo;
    logic [19:0] s_paddr;
    int          s_cyc = 0;

    function automatic logic [7:0] rom_byte(input logic [19:0] a);
        logic [7:0] v;
        v = a[7:0] ^ {a[11:8], a[19:16]} ^ 8'h3C;
        if (a == 20'h00010) v = 8'hA5;
        return v;
    endfunction

    // ROM model: PCM_OK rises a_dly cycles after CS and holds until CS drops.
    always @(posedge CLK96) a_cyc <= a_cs ? a_cyc + 1 : 0;
    assign a_pok   = a_cs && a_rom_en && (a_cyc >= a_dly);
    assign a_pdout = rom_byte(a_paddr);

    always @(posedge CLK96) s_cyc <= s_cs ? s_cyc + 1 : 0;
    assign s_pok   = s_cs && (s_cyc >= 1);
    assign s_pdout = rom_byte(s_paddr);

    toaplan2_pcm_arbiter #(.DUAL(1), .SETTLE(T_SETTLE), .TIMEOUT(T_TIMEOUT)) dut_a (
        .CLK96(CLK96), .RESET96(RESET96),
        .OKI0_ADDR(a0_addr), .OKI0_DOUT(a0_dout), .OKI0_OK(a0_ok),
        .OKI1_ADDR(a1_addr), .OKI1_DOUT(a1_dout), .OKI1_OK(a1_ok), .OKI1_BASE(a1_base),
        .PCM_CS(a_cs), .PCM_ADDR(a_paddr), .PCM_DOUT(a_pdout), .PCM_OK(a_pok),
        .TMO_ERR(a_tmo)
    );

    toaplan2_pcm_arbiter #(.DUAL(0), .SETTLE(T_SETTLE), .TIMEOUT(T_TIMEOUT)) dut_s (
        .CLK96(CLK96), .RESET96(RESET96),
        .OKI0_ADDR(s0_addr), .OKI0_DOUT(s0_dout), .OKI0_OK(s0_ok),
        .OKI1_ADDR(s1_addr), .OKI1_DOUT(s1_dout), .OKI1_OK(s1_ok), .OKI1_BASE(s1_base),
        .PCM_CS(s_cs), .PCM_ADDR(s_paddr), .PCM_DOUT(s_pdout), .PCM_OK(s_pok),
        .TMO_ERR(s_tmo)
    );

    task automatic tick();
        @(posedge CLK96);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic a_cond(input int kind);
        case (kind)
            0:       return a_cs;
            1:       return !a_cs;
            2:       return a0_ok;
            3:       return a1_ok;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_a(input string nm, input int kind, input int lim, output int n);
        n = 0;
        while (!a_cond(kind) && n < lim) begin
            tick();
            n++;
        end
        if (!a_cond(kind)) begin
            checks++;
            errors++;
            $display("FAIL %s: condition still false after %0d cycles, required true", nm, lim);
        end
    endtask

    function automatic logic [17:0] pick();
        case ($urandom_range(0, 3))
            0:       return 18'h00010;
            1:       return 18'h00011;
            2:       return 18'h2FFFF;
            default: return 18'($urandom);
        endcase
    endfunction

    typedef struct packed {
        logic        ch;
        logic [17:0] addr;
        logic [19:0] base;
        logic [19:0] exp_pa;
    } vec_t;

    vec_t tbl [5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

    initial begin
        int n, h, bad_ok, bad_d, bad_addr, grants;
        logic cs_seen, s_cs_prev;

        tbl[0] = '{1'b0, 18'h00123, 20'h00000, 20'h00123};
        tbl[1] = '{1'b1, 18'h00020, 20'hFFFF0, 20'h00010};
        tbl[2] = '{1'b1, 18'h3FFFF, 20'h40000, 20'h7FFFF};
        tbl[3] = '{1'b0, 18'h3FFFF, 20'h00000, 20'h3FFFF};
        tbl[4] = '{1'b1, 18'h00000, 20'hC0000, 20'hC0000};

        // Reset state, then a single miss and its latency
        a0_addr = 18'h00010; a1_addr = 18'h00003; a1_base = 20'h40000;
        tick(); tick();
        chk("rst_cs", a_cs, 0);
        chk("rst_paddr", a_paddr, 0);
        chk("rst_tmo", a_tmo, 0);
        chk("rst_ok0", a0_ok, 0);
        chk("rst_ok1", a1_ok, 0);
        chk("rst_dout0", a0_dout, 0);
        chk("rst_dout1", a1_dout, 0);
        RESET96 = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            if (e == 1) begin
                chk("first_cs", a_cs, 1);
                chk("first_paddr", a_paddr, 20'h00010);
            end
            chk($sformatf("first_ok_edge%0d", e), a0_ok, (e == 4));
        end
        chk("first_dout", a0_dout, 8'hA5);
        chk("first_tmo", a_tmo, 0);
        wait_a("init_ch1_ok", 3, 40, n);
        chk("init_ch1_dout", a1_dout, rom_byte(20'h40003));
        wait_a("init_idle", 1, 10, n);

        // Single-channel misses, including base wrap
        for (int i = 0; i < 5; i++) begin
            if (tbl[i].ch) begin
                a1_base = tbl[i].base;
                a1_addr = tbl[i].addr;
            end else begin
                a0_addr = tbl[i].addr;
            end
            wait_a($sformatf("tbl%0d_cs", i), 0, 10, n);
            chk($sformatf("tbl%0d_paddr", i), a_paddr, tbl[i].exp_pa);
            wait_a($sformatf("tbl%0d_ok", i), tbl[i].ch ? 3 : 2, 20, n);
            chk($sformatf("tbl%0d_dout", i), tbl[i].ch ? a1_dout : a0_dout, rom_byte(tbl[i].exp_pa));
            wait_a($sformatf("tbl%0d_idle", i), 1, 10, n);
        end

        // Simultaneous misses: rr starts at ch0, CS gap of one cycle, next tie back to ch0
        a0_addr = 18'h00100; a1_addr = 18'h00200; a1_base = 20'h40000;
        RESET96 = 1'b1;
        tick();
        RESET96 = 1'b0;
        tick();
        chk("tie_cs", a_cs, 1);
        chk("tie_paddr0", a_paddr, 20'h00100);
        wait_a("tie_idle", 1, 20, n);
        wait_a("tie_cs2", 0, 10, n);
        chk("tie_cs_gap", n, 1);
        chk("tie_paddr1", a_paddr, 20'h40200);
        wait_a("tie_ok1", 3, 20, n);
        chk("tie_dout1", a1_dout, rom_byte(20'h40200));
        chk("tie_ok0_held", a0_ok, 1);
        wait_a("tie_idle2", 1, 10, n);
        a0_addr = 18'h00101; a1_addr = 18'h00201;
        tick();
        chk("tie2_cs", a_cs, 1);
        chk("tie2_ch0_first", a_paddr, 20'h00101);
        wait_a("tie2_ok0", 2, 20, n);
        wait_a("tie2_ok1", 3, 20, n);
        wait_a("tie2_idle", 1, 10, n);

        // Address moves while the fetch is in WAIT
        a_dly = 5;
        a0_addr = 18'h00010;
        tick();
        chk("mid_cs", a_cs, 1);
        chk("mid_paddr", a_paddr, 20'h00010);
        tick(); tick();
        a0_addr = 18'h00011;
        wait_a("mid_idle", 1, 20, n);
        chk("mid_ok0_low", a0_ok, 0);
        wait_a("mid_cs2", 0, 10, n);
        chk("mid_cs_gap", n, 1);
        chk("mid_paddr2", a_paddr, 20'h00011);
        wait_a("mid_ok0", 2, 20, n);
        chk("mid_dout", a0_dout, rom_byte(20'h00011));
        a0_addr = 18'h00010;
        #1;
        chk("mid_drop_same_cycle", a0_ok, 0);
        a0_addr = 18'h00011;
        #1;
        chk("mid_return_hit", a0_ok, 1);
        cs_seen = 1'b0;
        repeat (6) begin
            tick();
            if (a_cs) cs_seen = 1'b1;
        end
        chk("mid_hit_no_cs", cs_seen, 0);
        a_dly = 1;

        // Timeout: CS held SETTLE+TIMEOUT cycles, sticky error, retry, reset clears
        chk("tmo_pre_ok1", a1_ok, 1);
        a_rom_en = 1'b0;
        a0_addr = 18'h00055;
        wait_a("tmo_cs", 0, 5, n);
        h = 1;
        while (a_cs && h < 400) begin
            tick();
            if (a_cs) h++;
        end
        chk("tmo_cs_cycles", h, T_SETTLE + T_TIMEOUT);
        chk("tmo_err", a_tmo, 1);
        chk("tmo_cs_low", a_cs, 0);
        tick();
        chk("tmo_retry_cs", a_cs, 1);
        chk("tmo_retry_paddr", a_paddr, 20'h00055);
        RESET96 = 1'b1;
        tick();
        RESET96 = 1'b0;
        chk("tmo_rst_err", a_tmo, 0);
        chk("tmo_rst_ok1", a1_ok, 0);
        chk("tmo_rst_cs", a_cs, 0);
        a_rom_en = 1'b1;

        // Random traffic: whenever OK is high, the byte must be ROM[addr + base]
        for (int ph = 0; ph < 30; ph++) begin
            a1_base = 20'($urandom);
            a_dly   = $urandom_range(0, 6);
            a0_addr = pick();
            a1_addr = pick();
            RESET96 = 1'b1;
            tick();
            RESET96 = 1'b0;
            repeat (60) begin
                tick();
                if (a0_ok) chk("rnd_dout0", a0_dout, rom_byte({2'b00, a0_addr}));
                if (a1_ok) chk("rnd_dout1", a1_dout, rom_byte({2'b00, a1_addr} + a1_base));
                if ($urandom_range(0, 7) == 0) a0_addr = pick();
                if ($urandom_range(0, 7) == 0) a1_addr = pick();
            end
            repeat (30) tick();
            chk($sformatf("rnd%0d_live0", ph), a0_ok, 1);
            chk($sformatf("rnd%0d_live1", ph), a1_ok, 1);
            chk($sformatf("rnd%0d_live_d1", ph), a1_dout, rom_byte({2'b00, a1_addr} + a1_base));
            chk($sformatf("rnd%0d_tmo", ph), a_tmo, 0);
        end

        // DUAL=0: channel 1 is inert, channel 0 behaves as before
        bad_ok = 0; bad_d = 0; bad_addr = 0; grants = 0;
        s_cs_prev = s_cs;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (s1_ok) bad_ok++;
            if (s1_dout != 8'h00) bad_d++;
            if (s_cs && !s_cs_prev) begin
                grants++;
                if (s_paddr != {2'b00, s0_addr}) bad_addr++;
            end
            if (s0_ok) chk("dual0_dout0", s0_dout, rom_byte({2'b00, s0_addr}));
            s_cs_prev = s_cs;
            if (c % 3 == 0) s1_addr = 18'($urandom);
            if (c % 25 == 0) s0_addr = pick();
        end
        chk("dual0_ok1_never", bad_ok, 0);
        chk("dual0_dout1_zero", bad_d, 0);
        chk("dual0_only_ch0_addr", bad_addr, 0);
        chk("dual0_grants_seen", (grants > 0), 1);
        repeat (20) tick();
        chk("dual0_live0", s0_ok, 1);
        chk("dual0_tmo", s_tmo, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/toaplan2_pcm_arbiter.md
Name: toaplan2_pcm_arbiter

Overview:
- Shares the single PCM ROM (SDRAM) port between two jt6295 ADPCM instances, for dual-OKI Toaplan2 boards.
- Each OKI sees a private ROM interface with address, data and ok.
- The block holds one cached byte per channel and serves misses round-robin on the shared port.
- Sits in the sound module between the jt6295 rom_addr/rom_data/rom_ok pins and the top-level PCM_CS/PCM_ADDR/PCM_DOUT/PCM_OK.

Parameters:
- DUAL, 1, 1 enables channel 1; 0 ties channel 1 off (OKI1_OK=0, OKI1_DOUT=0, never granted).
- SETTLE, 2, cycles after issuing an address during which PCM_OK is ignored (range 1..15).
- TIMEOUT, 255, cycles in WAIT before the transaction is aborted (range 16..1023).

Ports:
- CLK96  in  1  sound clock; the only clock.
- RESET96  in  1  synchronous, active-high reset.
- OKI0_ADDR  in  18  channel 0 byte address (jt6295 rom_addr).
- OKI0_DOUT  out  8  channel 0 data (to rom_data).
- OKI0_OK  out  1  channel 0 data valid for the current OKI0_ADDR (to rom_ok).
- OKI1_ADDR  in  18  channel 1 byte address.
- OKI1_DOUT  out  8  channel 1 data.
- OKI1_OK  out  1  channel 1 data valid.
- OKI1_BASE  in  20  PCM ROM byte offset of channel 1's region; channel 0 offset is 0.
- PCM_CS  out  1  shared port request.
- PCM_ADDR  out  20  shared port byte address.
- PCM_DOUT  in  8  shared port data.
- PCM_OK  in  1  shared port data valid.
- TMO_ERR  out  1  sticky flag: a transaction timed out.

Behaviour:
- Reset (synchronous, RESET96 high at a CLK96 edge):
  - state=IDLE, rr pointer=0;
  - per channel: valid=0, tag=0, data=0;
  - PCM_CS=0, PCM_ADDR=0, TMO_ERR=0, OKIn_DOUT=0.
  - Asserting reset mid-transaction aborts it: nothing is captured and no flags change beyond the reset values.
- Per-channel slot:
  - Registers valid, tag[17:0], data[7:0].
  - OKIn_OK = valid && (OKIn_ADDR == tag), combinational, so an address change drops OK in the same cycle.
  - OKIn_DOUT = data.
  - pending_n = !OKIn_OK (channel 1 masked when DUAL=0).
- FSM states: IDLE, SETTLE, WAIT.
  - IDLE:
    - PCM_CS=0.
    - If exactly one channel is pending, grant it.
    - If both are pending, grant the channel selected by rr.
    - On grant: lat_addr <= OKIn_ADDR, g <= n, PCM_ADDR <= {2'b0,lat} + base_n (20-bit, modulo 2^20 wrap), PCM_CS <= 1, cnt <= 0, go to SETTLE.
  - SETTLE:
    - PCM_OK is ignored.
    - cnt increments; when cnt == SETTLE-1, go to WAIT with cnt <= 0.
  - WAIT, on PCM_OK=1:
    - slot[g] gets data <= PCM_DOUT, tag <= lat_addr, valid <= 1.
    - PCM_CS <= 0; rr <= !g (the other channel gets priority next); go to IDLE.
  - WAIT, on cnt == TIMEOUT-1 without PCM_OK:
    - PCM_CS <= 0; TMO_ERR <= 1; rr <= !g; go to IDLE.
    - The slot is not updated, so the channel re-requests.
- PCM_CS is low for at least one cycle (IDLE) between consecutive transactions, so the SDRAM controller sees a fresh request.
- Latency: address change seen at edge k gives earliest OK at edge k+SETTLE+2 (PCM_OK already high). Default SETTLE gives 4 cycles.
- Requester changes its address during SETTLE/WAIT:
  - the transaction completes with lat_addr and its data is cached;
  - OK stays low because the tag mismatches, and the new address is requested next.
- A requester returning to the cached address gets OK with no transaction (hit).
- PCM_ADDR holds its last value while idle.
- The slot write at WAIT completion and a same-cycle address change on that channel do not conflict: the tag compare uses the registered tag in the following cycle.

Decomposition:
- Shared package toaplan2_snd_pkg holds:
  - the FSM state encoding (IDLE/SETTLE/WAIT);
  - PCM_AW=20 and OKI_AW=18 width constants;
  - the channel index type.
- One sub-module, toaplan2_pcm_slot: a single channel's valid/tag/data registers, the compare, and the OK/DOUT outputs. It is instantiated twice, with the second instance's load gated by DUAL.

Test Plan:
- Reset, then OKI0_ADDR=18'h00010 with ROM model returning 8'hA5 and PCM_OK 1 cycle after CS: PCM_ADDR=20'h00010, OKI0_OK rises at edge 4, OKI0_DOUT=A5, TMO_ERR=0.
- Both channels miss in the same cycle, OKI0=18'h00100, OKI1=18'h00200, OKI1_BASE=20'h40000: grants go ch0 first (PCM_ADDR=00100), then ch1 (PCM_ADDR=40200). PCM_CS is low for one cycle between them, and the next tie goes to ch0.
- OKI1_BASE=20'hFFFF0, OKI1_ADDR=18'h00020: PCM_ADDR=20'h00010 (wrap).
- OKI0_ADDR changed from 18'h00010 to 18'h00011 during WAIT: the first transaction completes and is cached, OKI0_OK stays 0, and a second transaction issues for 00011. Returning to the cached address gives OKI0_OK=1 with no PCM_CS pulse.
- PCM_OK never asserted: after SETTLE+TIMEOUT cycles PCM_CS=0, TMO_ERR=1, and the channel retries. Reset clears TMO_ERR and OKIn_OK.
- DUAL=0 with OKI1_ADDR toggling: OKI1_OK=0 and ch1 is never granted; ch0 hit/miss behaviour is unchanged.
